imem_loader: RTL
================

# imem_loader

Writer for the processor's instruction memory. It accepts a byte stream over a valid/ready handshake from a UART receiver or a test harness, assembles little-endian 32-bit instruction words, and issues one-cycle word writes to the instruction memory's write port. While loading, it holds the ARM pipelined core in reset, then releases the core only after the checksum matches. It sits between the host link and the instruction memory, beside the core.

## Interface
- DEPTH, 64: instruction memory size in 32-bit words; legal header values are 1..DEPTH.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- we  out  1  instruction memory write enable, one-cycle pulse.
- wa  out  32  byte address of the write, word aligned (wa[1:0]=0), so the memory indexes with wa[31:2].
- wd  out  32  instruction word to write.
- cpu_reset  out  1  holds the core in reset.
- busy  out  1  a load is in progress.
- done  out  1  last load completed with a good checksum.
- error  out  1  last load aborted (bad header or bad checksum).

## Operation
- Stream format: header byte N (word count), then 4·N data bytes, least-significant byte first per word, then one checksum byte. The checksum byte equals the XOR of the header and all data bytes.
- A byte is accepted on the cycle where byte_valid and byte_ready are both high.
- FSM states:
  - IDLE: reset state. byte_ready=0, cpu_reset=0. Goes to HDR on start.
  - HDR: byte_ready=1. On acceptance, N=0 or N>DEPTH goes to ERR. Otherwise latch N, clear the word index and byte count, seed chk=N, and go to DATA.
  - DATA: byte_ready=1. Each accepted byte shifts into lane byte_cnt of the assembly register and XORs into chk. When the 4th byte is accepted, go to WRITE.
  - WRITE: byte_ready=0. we=1, wa=idx<<2, wd=assembled word. Increment idx. If idx+1==N go to CHK, else go to DATA.
  - CHK: byte_ready=1. On acceptance, byte==chk goes to DONE, otherwise ERR.
  - DONE: done=1, cpu_reset=0. Goes to HDR on start.
  - ERR: error=1, cpu_reset=1. Goes to HDR on start.
- busy=1 and cpu_reset=1 in HDR, DATA, WRITE and CHK.
- done and error are cleared on the transition into HDR.
- start is ignored in HDR, DATA, WRITE and CHK. The loader has no abort path other than reset.
- we is 0 in every state except WRITE. wa and wd hold their last values outside WRITE.
- Words already written before an ERR stay in memory. Nothing is rolled back.

## Timing
- Reset values: state IDLE, byte_ready 0, we 0, wa 0, wd 0, cpu_reset 0, busy 0, done 0, error 0, idx 0, byte_cnt 0, chk 0.
- All outputs are registered or decoded from state only. No output depends combinationally on byte_valid or byte_data.
- Latency from the 4th byte's acceptance edge to the we pulse: 1 cycle. That cycle is the WRITE state.
- Minimum load time for N words at full rate: 1 (header) + 5N (4 data bytes plus 1 WRITE cycle each) + 1 (checksum) cycles.
- Stall tolerance: any number of idle cycles with byte_valid=0 between bytes leaves the state unchanged.
- Reset asserted mid-load returns to IDLE on the next edge. cpu_reset drops to 0 and no further write is issued. A WRITE cycle coinciding with reset still drives we=0.
- After DONE, cpu_reset falls in the same cycle that done rises.
- N=DEPTH: the final write goes to wa=4·(DEPTH-1). idx never wraps.

## Structure
- Package imem_loader_pkg holds:
  - state enum typedef (IDLE, HDR, DATA, WRITE, CHK, DONE, ERR);
  - DEPTH default;
  - IDX_W = $clog2(DEPTH+1).
- One natural sub-module, word_assembler:
  - 2-bit byte counter, 32-bit shift/lane register, running XOR;
  - clear and shift inputs; full flag and word outputs.
- Top level is the FSM plus the idx/N registers.

## Test plan
- Good 2-word load: bytes 02, 01 00 A0 E3, 02 10 80 E2, 30 → exactly two we pulses (wa=0x0, wd=0xE3A00001; wa=0x4, wd=0xE2801002), then done=1, error=0, cpu_reset=0.
- Same stream with checksum 31 → both writes occur, then error=1, done=0, cpu_reset stays 1.
- Header 00 and, separately, header 41 (DEPTH=64) → ERR immediately after the header, no we pulse, and no further bytes accepted (byte_ready=0).
- Good 2-word load with byte_valid randomly deasserted about 50% of the time → identical writes and identical final state. we is never high while byte_ready is high.
- Reset asserted after the 6th data byte → next cycle state IDLE, all outputs at reset values. A subsequent start plus a full good stream loads correctly.
- Full DEPTH=64 load of word value idx·0x01010101 → 64 writes, last at wa=0xFC. start pulses sent mid-load are ignored. A start from DONE begins a new load and clears done.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader.
// Holds the loader FSM state encoding, the default memory depth and the index width.
package imem_loader_pkg;

    // Default instruction memory size in 32-bit words.
    localparam int DEFAULT_DEPTH = 64;

    // Word index / word count width; must hold the value DEPTH itself.
    localparam int IDX_W = $clog2(DEFAULT_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CHK   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_e;

    // Index width required for an arbitrary depth.
    function automatic int idx_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs four stream bytes little-endian into one 32-bit word and
// keeps the running XOR checksum of the stream.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart a load; seeds the checksum with byte_in (the header)
//   shift       : accept byte_in into lane byte_cnt and fold it into the checksum
//   byte_in     : stream byte
//   full        : the next shift completes a word
//   word        : assembled word including byte_in in the current lane
//   chk         : running XOR of the header and all shifted bytes
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic        full,
    output logic [31:0] word,
    output logic [7:0]  chk
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] lanes_q, lanes_d;
    logic [7:0]  chk_q, chk_d;
    logic [31:0] word_nxt;

    // The word is presented with the in-flight byte already merged so the
    // write data can be captured on the same edge that accepts the 4th byte.
    always_comb begin
        word_nxt = lanes_q;
        unique case (cnt_q)
            2'd0: word_nxt[7:0]   = byte_in;
            2'd1: word_nxt[15:8]  = byte_in;
            2'd2: word_nxt[23:16] = byte_in;
            2'd3: word_nxt[31:24] = byte_in;
            default: word_nxt = lanes_q;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        lanes_d = lanes_q;
        chk_d   = chk_q;
        if (clear) begin
            cnt_d   = 2'd0;
            lanes_d = 32'd0;
            chk_d   = byte_in;
        end else if (shift) begin
            cnt_d   = cnt_q + 2'd1;
            lanes_d = word_nxt;
            chk_d   = chk_q ^ byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            lanes_q <= 32'd0;
            chk_q   <= 8'd0;
        end else begin
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
            chk_q   <= chk_d;
        end
    end

    assign full = (cnt_q == 2'd3);
    assign word = word_nxt;
    assign chk  = chk_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads the instruction memory from a byte stream (header N, 4*N data
// bytes LSB first, XOR checksum) and holds the core in reset until the load checks out.
//   clk, reset           : clock, synchronous active-high reset
//   start                : begin a load from IDLE, DONE or ERR
//   byte_valid/byte_data : stream input, byte_ready is the accept handshake
//   we, wa, wd           : one-cycle word write to the instruction memory
//   cpu_reset            : core reset hold
//   busy, done, error    : load in progress / last load good / last load aborted
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int IW = idx_width(DEPTH);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   n_q, n_d;

    logic            byte_ready_q;
    logic            we_q;
    logic [31:0]     wa_q;
    logic [31:0]     wd_q;
    logic            cpu_reset_q;
    logic            busy_q;
    logic            done_q;
    logic            error_q;

    logic            accept;
    logic            hdr_bad;
    logic            last_word;
    logic            asm_clear;
    logic            asm_shift;
    logic            asm_full;
    logic [31:0]     asm_word;
    logic [7:0]      asm_chk;

    word_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .clear   (asm_clear),
        .shift   (asm_shift),
        .byte_in (byte_data),
        .full    (asm_full),
        .word    (asm_word),
        .chk     (asm_chk)
    );

    assign accept    = byte_valid & byte_ready_q;
    assign hdr_bad   = (byte_data == 8'd0) || (int'(byte_data) > DEPTH);
    assign last_word = ((idx_q + IW'(1)) == n_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        asm_clear = 1'b0;
        asm_shift = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    if (hdr_bad) begin
                        state_d = ERR;
                    end else begin
                        n_d       = IW'(byte_data);
                        idx_d     = '0;
                        asm_clear = 1'b1;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    if (asm_full) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_d   = idx_q + IW'(1);
                state_d = last_word ? CHK : DATA;
            end
            CHK: begin
                if (accept) begin
                    state_d = (byte_data == asm_chk) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is registered from the next state, so none of them
    // depends on the stream inputs within a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            n_q          <= '0;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            wa_q         <= 32'd0;
            wd_q         <= 32'd0;
            cpu_reset_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            byte_ready_q <= (state_d inside {HDR, DATA, CHK});
            busy_q       <= (state_d inside {HDR, DATA, WRITE, CHK});
            cpu_reset_q  <= (state_d inside {HDR, DATA, WRITE, CHK, ERR});
            done_q       <= (state_d == DONE);
            error_q      <= (state_d == ERR);
            we_q         <= (state_d == WRITE);
            if (state_d == WRITE) begin
                wa_q <= 32'(idx_q) << 2;
                wd_q <= asm_word;
            end
        end
    end

    // A WRITE cycle that coincides with reset must not reach the memory.
    assign we         = we_q & ~reset;
    assign byte_ready = byte_ready_q;
    assign wa         = wa_q;
    assign wd         = wd_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
